// File: rtl/leb128_pkg.sv
// Shared constants and types for the LEB128 decoders.
// Latency: none (definitions only).
// Backpressure: not applicable.
package leb128_pkg;

    localparam int LEB128_MAX_BYTES_U32 = 5;
    localparam int LEB128_PAYLOAD_BITS  = 7;
    localparam int LEB128_CONT_BIT      = 7;

    typedef logic [31:0] u32_t;

    typedef struct packed {
        u32_t       value;
        logic [2:0] len;
        logic       err;
    } leb128_u32_res_t;

endpackage

// File: rtl/leb128_reach_mask.sv
// Maps continuation bits of bytes 0..3 to a reached-byte mask and encoded length.
// Latency: combinational.
// Backpressure: none.
module leb128_reach_mask (
    input  logic [3:0] cont,
    output logic [4:0] reach,
    output logic [2:0] len
);

    // Byte k is reached when every earlier byte carries a continuation bit.
    assign reach = {&cont[3:0], &cont[2:0], &cont[1:0], cont[0], 1'b1};

    // Scan downward so the lowest terminating byte wins.
    always_comb begin
        len = 3'd5;
        for (int k = 3; k >= 0; k--) begin
            if (!cont[k]) len = 3'(k + 1);
        end
    end

endmodule

// File: rtl/leb128_unpack_u32.sv
// Decodes a 5-byte-aligned unsigned LEB128 candidate into u32 value, length and error.
// Latency: 1 cycle, out_valid is in_valid delayed by one clock.
// Backpressure: none; accepts a new candidate every cycle.
module leb128_unpack_u32
    import leb128_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  i0,
    input  logic [7:0]  i1,
    input  logic [7:0]  i2,
    input  logic [7:0]  i3,
    input  logic [7:0]  i4,
    output logic [31:0] o,
    output logic [2:0]  len,
    output logic        err,
    output logic        out_valid
);

    logic [7:0]      bytes_dat [LEB128_MAX_BYTES_U32];
    logic [4:0]      reach;
    logic [2:0]      len_c;
    leb128_u32_res_t res_c;
    leb128_u32_res_t res_q;
    logic            vld_q;

    assign bytes_dat[0] = i0;
    assign bytes_dat[1] = i1;
    assign bytes_dat[2] = i2;
    assign bytes_dat[3] = i3;
    assign bytes_dat[4] = i4;

    leb128_reach_mask u_reach_mask (
        .cont  ({i3[LEB128_CONT_BIT], i2[LEB128_CONT_BIT],
                 i1[LEB128_CONT_BIT], i0[LEB128_CONT_BIT]}),
        .reach (reach),
        .len   (len_c)
    );

    always_comb begin
        res_c = '0;
        for (int k = 0; k < LEB128_MAX_BYTES_U32 - 1; k++) begin
            res_c.value[k*LEB128_PAYLOAD_BITS +: LEB128_PAYLOAD_BITS] =
                reach[k] ? bytes_dat[k][LEB128_PAYLOAD_BITS-1:0] : '0;
        end
        // Only the low nibble of the fifth byte fits in 32 bits.
        res_c.value[31:28] = reach[4] ? i4[3:0] : 4'd0;
        res_c.len          = len_c;
        res_c.err          = reach[4] & (i4[LEB128_CONT_BIT] | (|i4[6:4]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) res_q <= res_c;
        end
    end

    assign o         = res_q.value;
    assign len       = res_q.len;
    assign err       = res_q.err;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_leb128_unpack_u32.sv
// Directed and randomized checks of leb128_unpack_u32 against an arithmetic model.
module tb_leb128_unpack_u32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  i0 = '0, i1 = '0, i2 = '0, i3 = '0, i4 = '0;
    logic [31:0] o;
    logic [2:0]  len;
    logic        err;
    logic        out_valid;

    int tests = 0;
    int fails = 0;

    logic [31:0] last_o;
    logic [2:0]  last_len;
    logic        last_err;

    always #5 clk = ~clk;

    leb128_unpack_u32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .i0        (i0),
        .i1        (i1),
        .i2        (i2),
        .i3        (i3),
        .i4        (i4),
        .o         (o),
        .len       (len),
        .err       (err),
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Walk the bytes as a stream: accumulate payload*128^k until a byte below 0x80.
    task automatic model(input logic [39:0] w, output logic [31:0] v,
                         output int n, output logic e);
        longint unsigned acc;
        int unsigned     b;
        acc = 0;
        n   = 0;
        b   = 0;
        for (int k = 0; k < 5; k++) begin
            b   = int'(w[8*k +: 8]);
            acc = acc + longint'(b % 128) * (longint'(1) << (7 * k));
            n   = k + 1;
            if (b < 128) break;
        end
        v = acc[31:0];
        e = (n == 5) && (b >= 16);
    endtask

    task automatic apply(input string tag, input logic [39:0] w);
        logic [31:0] ev;
        int          en;
        logic        ee;
        {i4, i3, i2, i1, i0} = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        model(w, ev, en, ee);
        chk({tag, ".o"},   o, ev);
        chk({tag, ".len"}, {29'd0, len}, 32'(en));
        chk({tag, ".err"}, {31'd0, err}, {31'd0, ee});
        chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
        last_o   = ev;
        last_len = 3'(en);
        last_err = ee;
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        {i4, i3, i2, i1, i0} = 40'h55_AA_55_AA_55;
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".o"},   o, last_o);
        chk({tag, ".len"}, {29'd0, len}, {29'd0, last_len});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, last_err});
    endtask

    initial begin
        logic [39:0] w;
        int          l;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst.o",   o, 32'd0);
        chk("rst.len", {29'd0, len}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        chk("rst.vld", {31'd0, out_valid}, 32'd0);
        #4 rst = 1'b0;

        // Directed cases, with fixed expectations alongside the model.
        apply("zero", 40'h00_00_00_00_00);
        chk("zero.fix", o, 32'd0);
        apply("classic", 40'h00_00_26_8E_E5);
        chk("classic.fix", o, 32'd624485);
        chk("classic.len_fix", {29'd0, len}, 32'd3);
        apply("max", 40'h0F_FF_FF_FF_FF);
        chk("max.fix", o, 32'hFFFF_FFFF);
        chk("max.err_fix", {31'd0, err}, 32'd0);
        apply("trail", 40'hFF_FF_FF_FF_7F);
        chk("trail.fix", o, 32'h0000_007F);
        chk("trail.len_fix", {29'd0, len}, 32'd1);
        apply("pad", 40'h00_00_00_00_80);
        chk("pad.len_fix", {29'd0, len}, 32'd2);
        apply("ovf", 40'h1F_FF_FF_FF_FF);
        chk("ovf.err_fix", {31'd0, err}, 32'd1);
        chk("ovf.o_fix", o, 32'hFFFF_FFFF);
        apply("long", 40'h80_80_80_80_80);
        chk("long.err_fix", {31'd0, err}, 32'd1);
        chk("long.len_fix", {29'd0, len}, 32'd5);
        idle("idle0");
        apply("nib", 40'h70_80_80_80_80);
        chk("nib.err_fix", {31'd0, err}, 32'd1);
        apply("len4", 40'hFF_7F_80_80_81);
        chk("len4.fix", o, 32'h0FE0_0001);

        // Randomized back-to-back traffic with occasional idle cycles.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                w[31:0]  = $urandom;
                w[39:32] = 8'($urandom);
            end else begin
                l = $urandom_range(1, 5);
                for (int k = 0; k < 5; k++) begin
                    w[8*k +: 8] = 8'($urandom);
                    if (k < l - 1) w[8*k + 7] = 1'b1;
                    else if (k == l - 1 && k < 4) w[8*k + 7] = 1'b0;
                end
            end
            apply("rand", w);
            if ($urandom_range(0, 9) == 0) idle("rand_idle");
        end

        // Reset asserted between edges discards the pending result at once.
        apply("pre_rst", 40'h00_00_26_8E_E5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst.o",   o, 32'd0);
        chk("mid_rst.len", {29'd0, len}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst", 40'h00_00_00_01_FF);

        in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
